// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the clk_div_bank clock divider bank.
//   state_e   - bank sequencing states (IDLE, SETTLE, LOCKED, APPLY)
//   sel_width - channel-select width for a given channel count (never below 1)
//   cnt_start - channel counter start value (div - phase) mod div
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2,
    ST_APPLY  = 2'd3
  } state_e;

  // Widest divisor field the helpers below accept.
  localparam int MAX_DIV_W = 32;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accepted configurations always have phase < div, so the modulo reduces
  // to a subtract with phase == 0 mapping to 0. Out-of-range phases (only
  // possible through bad parameter defaults) also fall back to 0.
  function automatic logic [MAX_DIV_W-1:0] cnt_start(
    input logic [MAX_DIV_W-1:0] div,
    input logic [MAX_DIV_W-1:0] phase
  );
    logic [MAX_DIV_W-1:0] res;
    if (phase == 32'd0) begin
      res = 32'd0;
    end else if (phase < div) begin
      res = div - phase;
    end else begin
      res = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: configuration request channel of clk_div_bank.
//   cfg_valid/cfg_ready - request handshake (transfer when both high on refclk)
//   cfg_sel             - target channel
//   cfg_div/high/phase  - period, high time and first-edge delay in refclk cycles
//   cfg_err             - one-cycle pulse when a request was rejected
// master: requester side; slave: clk_div_bank side.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CLOCKS = 4,
  parameter int DIV_W      = 16
);

  localparam int SEL_W = sel_width(NUM_CLOCKS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_sel;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_high;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_sel, cfg_div, cfg_high, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_div, cfg_high, cfg_phase,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel of clk_div_bank.
//   refclk, rst   - clock and asynchronous active-high reset
//   wr_en_i       - load div_i/high_i/phase_i into the channel registers
//   restart_i     - reload the counter so the next cycle is pattern step 0
//   div_i, high_i, phase_i - new configuration (already validated)
//   level_o       - combinational channel level (cnt < high)
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DEF_DIV   = 25,
  parameter int DEF_HIGH  = 12,
  parameter int DEF_PHASE = 0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] high_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             level_o
);

  localparam logic [DIV_W-1:0] CNT_RST =
    DIV_W'(cnt_start(32'(DEF_DIV), 32'(DEF_PHASE)));

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] high_q;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] start_s;

  // Restart reads the registers written one cycle earlier, so the start
  // value always reflects the configuration being settled.
  assign start_s = DIV_W'(cnt_start(32'(div_q), 32'(phase_q)));

  // Configuration registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div_q   <= DIV_W'(DEF_DIV);
      high_q  <= DIV_W'(DEF_HIGH);
      phase_q <= DIV_W'(DEF_PHASE);
    end else if (wr_en_i) begin
      div_q   <= div_i;
      high_q  <= high_i;
      phase_q <= phase_i;
    end
  end

  // Counter next state: reload on restart, else count and wrap at div-1.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = start_s;
    end else if (cnt_q >= (div_q - DIV_W'(1))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // high = 0 never matches (constant low); high >= div always matches.
  assign level_o = (cnt_q < high_q);

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CLOCKS runtime-configurable integer clock dividers with
// a PLL-style lock model.
//   refclk  - sole clock, rising edge
//   rst     - asynchronous active-high reset
//   cfg     - configuration request channel (clk_div_bank_if.slave)
//   outclk  - registered divided clocks, gated low while not locked
//   locked  - all channels running with the current configuration
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEF_DIV     = 25,
  parameter int DEF_HIGH    = 12,
  parameter int DEF_PHASE   = 0
) (
  input  logic                  refclk,
  input  logic                  rst,
  clk_div_bank_if.slave         cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int SEL_W = sel_width(NUM_CLOCKS);
  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(LOCK_CYCLES - 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [SET_W-1:0]        settle_q;
  logic [SET_W-1:0]        settle_d;
  logic                    locked_q;
  logic                    locked_d;
  logic                    ready_q;
  logic                    ready_d;
  logic                    err_q;
  logic                    err_d;
  logic [NUM_CLOCKS-1:0]   outclk_q;
  logic [NUM_CLOCKS-1:0]   level_s;
  logic [NUM_CLOCKS-1:0]   wr_en_s;
  logic                    hs_s;
  logic                    req_ok_s;
  logic                    apply_s;
  logic                    restart_s;

  // ready_q is high only in SETTLE/LOCKED, so hs_s implies one of those.
  assign hs_s     = cfg.cfg_valid & ready_q;
  assign req_ok_s = (cfg.cfg_div >= DIV_W'(2)) &&
                    (cfg.cfg_phase < cfg.cfg_div) &&
                    ({1'b0, cfg.cfg_sel} < (SEL_W + 1)'(NUM_CLOCKS));
  assign apply_s  = hs_s & req_ok_s;

  // Counters reload in the cycle before SETTLE entry so that SETTLE's first
  // cycle is pattern step k = 0 for every channel.
  assign restart_s = (state_q == ST_IDLE) || (state_q == ST_APPLY);

  // Sequencing next state, settle countdown and registered-output next values.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    err_d    = hs_s & ~req_ok_s;
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_SETTLE;
        settle_d = SETTLE_INIT;
      end
      ST_SETTLE: begin
        if (apply_s) begin
          state_d = ST_APPLY;
        end else if (settle_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_LOCKED: begin
        if (apply_s) begin
          state_d = ST_APPLY;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_APPLY: begin
        state_d  = ST_SETTLE;
        settle_d = SETTLE_INIT;
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = SETTLE_INIT;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);
    ready_d  = (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
  end

  // Sequencing and status registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= SETTLE_INIT;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    assign wr_en_s[i] = apply_s & (cfg.cfg_sel == SEL_W'(i));

    clk_div_chan #(
      .DIV_W     (DIV_W),
      .DEF_DIV   (DEF_DIV),
      .DEF_HIGH  (DEF_HIGH),
      .DEF_PHASE (DEF_PHASE)
    ) u_chan (
      .refclk    (refclk),
      .rst       (rst),
      .wr_en_i   (wr_en_s[i]),
      .restart_i (restart_s),
      .div_i     (cfg.cfg_div),
      .high_i    (cfg.cfg_high),
      .phase_i   (cfg.cfg_phase),
      .level_o   (level_s[i])
    );
  end

  // Output clocks: one flop per channel keeps them glitch-free.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      outclk_q <= '0;
    end else begin
      outclk_q <= locked_q ? level_s : '0;
    end
  end

  assign outclk        = outclk_q;
  assign locked        = locked_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed stimulus with a cycle-level reference model of
// clk_div_bank (absolute-time settle tracking plus modular pattern formula),
// and a second small instance for the channel-select range check.
module tb_clk_div_bank;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int LC = 16;

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic [NC-1:0] outclk;
  logic          locked;
  logic [2:0]    outclk3;
  logic          locked3;

  clk_div_bank_if #(.NUM_CLOCKS(NC), .DIV_W(DW)) cfg_if ();
  clk_div_bank_if #(.NUM_CLOCKS(3),  .DIV_W(DW)) cfg3_if ();

  clk_div_bank #(
    .NUM_CLOCKS(NC), .DIV_W(DW), .LOCK_CYCLES(LC),
    .DEF_DIV(25), .DEF_HIGH(12), .DEF_PHASE(0)
  ) u_dut (
    .refclk(refclk), .rst(rst), .cfg(cfg_if), .outclk(outclk), .locked(locked)
  );

  clk_div_bank #(
    .NUM_CLOCKS(3), .DIV_W(DW), .LOCK_CYCLES(4),
    .DEF_DIV(25), .DEF_HIGH(12), .DEF_PHASE(0)
  ) u_dut3 (
    .refclk(refclk), .rst(rst), .cfg(cfg3_if), .outclk(outclk3), .locked(locked3)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_cyc = 0;
  int            m_settle_at = 0;
  bit            m_idle = 1'b1;
  bit            m_apply = 1'b0;
  bit            m_err = 1'b0;
  int            m_div  [NC];
  int            m_high [NC];
  int            m_phase[NC];
  logic [NC-1:0] m_prev_gate = '0;

  initial begin : compare
    logic [NC-1:0] gate;
    bit            lk;
    bit            rdy;
    int            k, r, d, p, s;
    forever begin
      @(negedge refclk);
      if (rst) begin
        check("rst_outclk", outclk, 0);
        check("rst_locked", locked, 0);
        check("rst_ready",  cfg_if.cfg_ready, 0);
        check("rst_err",    cfg_if.cfg_err, 0);
        for (int i = 0; i < NC; i++) begin
          m_div[i] = 25; m_high[i] = 12; m_phase[i] = 0;
        end
        m_idle = 1'b1; m_apply = 1'b0; m_err = 1'b0; m_prev_gate = '0;
      end else begin
        rdy  = !m_idle && !m_apply;
        lk   = rdy && ((m_cyc - m_settle_at) >= LC);
        gate = '0;
        if (lk) begin
          k = m_cyc - m_settle_at;
          for (int i = 0; i < NC; i++) begin
            r = ((k - m_phase[i]) % m_div[i] + m_div[i]) % m_div[i];
            gate[i] = (r < m_high[i]);
          end
        end
        check("model_outclk", outclk, m_prev_gate);
        check("model_locked", locked, lk);
        check("model_ready",  cfg_if.cfg_ready, rdy);
        check("model_err",    cfg_if.cfg_err, m_err);
        m_prev_gate = gate;
        m_err = 1'b0;
        if (m_idle) begin
          m_idle = 1'b0; m_settle_at = m_cyc + 1;
        end else if (m_apply) begin
          m_apply = 1'b0; m_settle_at = m_cyc + 1;
        end else if (cfg_if.cfg_valid) begin
          d = int'(cfg_if.cfg_div);
          p = int'(cfg_if.cfg_phase);
          s = int'(cfg_if.cfg_sel);
          if (d < 2 || p >= d || s >= NC) begin
            m_err = 1'b1;
          end else begin
            m_div[s] = d; m_high[s] = int'(cfg_if.cfg_high); m_phase[s] = p;
            m_apply = 1'b1;
          end
        end
      end
      m_cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic req(input int sel, input int div, input int high, input int phase);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 2'(sel);
    cfg_if.cfg_div   = 16'(div);
    cfg_if.cfg_high  = 16'(high);
    cfg_if.cfg_phase = 16'(phase);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic req3(input int sel, input int div, input int high, input int phase);
    cfg3_if.cfg_valid = 1'b1;
    cfg3_if.cfg_sel   = 2'(sel);
    cfg3_if.cfg_div   = 16'(div);
    cfg3_if.cfg_high  = 16'(high);
    cfg3_if.cfg_phase = 16'(phase);
    tick(1);
    cfg3_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int            n;
    int            ones0;
    int            ones2;
    logic [3:0]    pat;

    cfg_if.cfg_valid = 1'b0;  cfg_if.cfg_sel = '0;  cfg_if.cfg_div = '0;
    cfg_if.cfg_high  = '0;    cfg_if.cfg_phase = '0;
    cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_sel = '0; cfg3_if.cfg_div = '0;
    cfg3_if.cfg_high  = '0;   cfg3_if.cfg_phase = '0;
    rst = 1'b1;
    tick(3);
    check("reset_locked", locked, 0);
    check("reset_outclk", outclk, 0);

    // Defaults: lock 17 edges after release, period 25 / high 12, in phase.
    rst = 1'b0;
    wait_lock(n);
    check("lock_latency_release", n, 17);
    tick(9);  check("dflt_k25_low",  outclk, 4'h0);
    tick(1);  check("dflt_k26_high", outclk, 4'hF);
    tick(11); check("dflt_k37_high", outclk, 4'hF);
    tick(1);  check("dflt_k38_low",  outclk, 4'h0);
    ones0 = 0;
    for (int j = 0; j < 50; j++) begin
      tick(1);
      ones0 += int'(outclk[0]);
    end
    check("dflt_ones_in_50", ones0, 24);

    // Reconfigure ch1 to div 4 / high 1 / phase 2.
    req(1, 4, 1, 2);
    check("apply_locked_low", locked, 0);
    wait_lock(n);
    check("reconf_relock_edges", n, 17);
    pat = '0;
    for (int j = 0; j < 4; j++) begin
      tick(1);
      pat = {pat[2:0], outclk[1]};
    end
    check("ch1_pattern", pat, 4'b0010);

    // Invalid requests: err pulse, lock held.
    req(0, 1, 0, 0);
    check("err_div1", cfg_if.cfg_err, 1);
    check("err_div1_locked", locked, 1);
    tick(1);
    check("err_single_pulse", cfg_if.cfg_err, 0);
    req(0, 5, 2, 5);
    check("err_phase_eq_div", cfg_if.cfg_err, 1);
    check("err_phase_locked", locked, 1);
    tick(3);
    req3(3, 4, 1, 0);
    check("err_sel_range", cfg3_if.cfg_err, 1);
    check("err_sel_locked", locked3, 1);
    tick(1);
    req3(2, 4, 1, 0);
    check("sel_max_valid_err", cfg3_if.cfg_err, 0);
    check("sel_max_valid_apply", locked3, 0);
    tick(2);

    // Back-to-back: ch0 high 0, then ch2 high 30 five cycles into SETTLE.
    req(0, 25, 0, 0);
    tick(6);
    check("b2b_settling", locked, 0);
    req(2, 25, 30, 0);
    check("b2b_second_apply", locked, 0);
    wait_lock(n);
    check("b2b_relock_edges", n, 17);
    tick(1);
    ones0 = 0; ones2 = 0;
    for (int j = 0; j < 60; j++) begin
      ones0 += int'(outclk[0]);
      ones2 += int'(outclk[2]);
      tick(1);
    end
    check("high0_const_low",  ones0, 0);
    check("high30_const_high", ones2, 60);

    // Async reset mid high pulse.
    check("pre_rst_ch2_high", outclk[2], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outclk", outclk, 0);
    check("async_rst_locked", locked, 0);
    tick(2);
    rst = 1'b0;
    wait_lock(n);
    check("relock_after_rst", n, 17);
    tick(10); check("restored_k26_high", outclk, 4'hF);
    tick(12); check("restored_k38_low",  outclk, 4'h0);

    // Async reset mid SETTLE, with a phased ch3 request pending settle.
    req(3, 25, 12, 3);
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_settle_ready",  cfg_if.cfg_ready, 0);
    check("rst_mid_settle_locked", locked, 0);
    tick(2);
    rst = 1'b0;
    wait_lock(n);
    check("relock_after_settle_rst", n, 17);
    tick(10); check("ch3_phase_reset_k26", outclk, 4'hF);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
